// File: rtl/sb_pkg.sv
// Shared widths and record types for the store buffer and its memory port.
package sb_pkg;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] write_data;
        logic              memread;
        logic              memwrite;
    } mem_req_t;

endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage side of the store buffer: store handshake plus load lookup.
// Store handshake: a store transfers on a posedge where st_valid && st_ready;
// the stage holds st_addr/st_data stable until then, and st_ready never depends on st_valid.
interface store_buffer_if;
    import sb_pkg::*;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_hit;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_data, ld_hit
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_data, ld_hit
    );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-first address match over the live FIFO entries (oldest at head).
module store_buffer_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == ld_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM and data_memory; loads forward from it or read memory.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    store_buffer_if.slave          sb,
    input  logic [DATA_W-1:0]      mem_read_data,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic                   mem_memread,
    output logic                   mem_memwrite,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             match_hit;
    logic [DATA_W-1:0] match_data;
    logic             push;
    logic             pop;
    logic             ld_miss;
    mem_req_t         req;

    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_addr (sb.ld_addr),
        .hit     (match_hit),
        .data    (match_data)
    );

    assign sb.st_ready = (count != CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign push        = sb.st_valid && sb.st_ready;
    assign ld_miss     = sb.ld_valid && !match_hit;
    // Draining is suppressed while reset is asserted so discarded stores never reach memory.
    assign pop         = rst_n && !ld_miss && (count != '0);

    assign sb.ld_hit  = sb.ld_valid && match_hit;
    assign sb.ld_data = sb.ld_hit ? match_data : (ld_miss ? mem_read_data : '0);

    // A load miss owns the port; the drain waits a cycle.
    always_comb begin
        req = '0;
        if (ld_miss) begin
            req.address = sb.ld_addr;
            req.memread = 1'b1;
        end else if (pop) begin
            req.address    = entries[head].addr;
            req.write_data = entries[head].data;
            req.memwrite   = 1'b1;
        end
    end

    assign mem_address    = req.address;
    assign mem_write_data = req.write_data;
    assign mem_memread    = req.memread;
    assign mem_memwrite   = req.memwrite;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{addr: sb.st_addr, data: sb.st_data};
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data_memory behind the port.
module tb_store_buffer;
    import sb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] mem_read_data;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic              empty;
    logic [2:0]        count;

    logic [DATA_W-1:0] mem [0:8191];

    int checks = 0;
    int errors = 0;

    store_buffer_if sb ();

    store_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sb             (sb.slave),
        .mem_read_data  (mem_read_data),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .empty          (empty),
        .count          (count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory model: combinational read, write on posedge
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_address] <= mem_write_data;
    end

    typedef struct {
        logic        sv;
        logic [12:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [12:0] la;
        logic        rdy;
        logic        hit;
        logic [31:0] ldata;
        logic        mw;
        logic        mr;
        logic [12:0] maddr;
        logic [31:0] wdata;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sv, logic [12:0] sa, logic [31:0] sd, logic lv,
                                logic [12:0] la, logic rdy, logic hit, logic [31:0] ldata,
                                logic mw, logic mr, logic [12:0] maddr, logic [31:0] wdata,
                                logic [2:0] cnt);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
        v.rdy = rdy; v.hit = hit; v.ldata = ldata; v.mw = mw; v.mr = mr;
        v.maddr = maddr; v.wdata = wdata; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic sv, input logic [12:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [12:0] la);
        sb.st_valid = sv;
        sb.st_addr  = sa;
        sb.st_data  = sd;
        sb.ld_valid = lv;
        sb.ld_addr  = la;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, " empty"}, 32'(empty), 32'd1);
        check({tag, " count"}, 32'(count), 32'd0);
        check({tag, " st_ready"}, 32'(sb.st_ready), 32'd1);
        check({tag, " memwrite"}, 32'(mem_memwrite), 32'd0);
        check({tag, " memread"}, 32'(mem_memread), 32'd0);
        check({tag, " mem_address"}, 32'(mem_address), 32'd0);
        check({tag, " ld_data"}, ld_data_or(), 32'd0);
    endtask

    function automatic logic [31:0] ld_data_or();
        return sb.ld_data | 32'(sb.ld_hit);
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[13'h100] = 32'hCAFE0100;
        mem[13'h020] = 32'hD0D00020;

        rst_n = 1'b0;
        drive(0, '0, '0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            #1 idle_checks($sformatf("idle%0d", i));
            @(negedge clk);
        end

        //        sv sa      sd            lv la      rdy hit ldata         mw mr maddr   wdata         cnt
        vecs.push_back(mk(1, 13'h005, 32'h12345678, 0, 13'h000, 1, 0, 32'h0,        0, 0, 13'h000, 32'h0,        3'd1));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h005, 32'h12345678, 3'd0));
        vecs.push_back(mk(1, 13'h001, 32'h11,       1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd1));
        vecs.push_back(mk(1, 13'h002, 32'h22,       1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd2));
        vecs.push_back(mk(1, 13'h003, 32'h33,       1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd3));
        vecs.push_back(mk(1, 13'h004, 32'h44,       1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd4));
        vecs.push_back(mk(1, 13'h005, 32'h55,       1, 13'h100, 0, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd4));
        vecs.push_back(mk(1, 13'h005, 32'h55,       0, 13'h000, 0, 0, 32'h0,        1, 0, 13'h001, 32'h11,       3'd3));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h002, 32'h22,       3'd2));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h003, 32'h33,       3'd1));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h004, 32'h44,       3'd0));
        vecs.push_back(mk(1, 13'h010, 32'hAAAA0000, 1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd1));
        vecs.push_back(mk(1, 13'h010, 32'hBBBB0000, 1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd2));
        vecs.push_back(mk(0, 13'h000, 32'h0,        1, 13'h010, 1, 1, 32'hBBBB0000, 1, 0, 13'h010, 32'hAAAA0000, 3'd1));
        vecs.push_back(mk(0, 13'h000, 32'h0,        1, 13'h010, 1, 1, 32'hBBBB0000, 1, 0, 13'h010, 32'hBBBB0000, 3'd0));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        0, 0, 13'h000, 32'h0,        3'd0));
        vecs.push_back(mk(1, 13'h030, 32'h30,       1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd1));
        vecs.push_back(mk(1, 13'h031, 32'h31,       1, 13'h100, 1, 0, 32'hCAFE0100, 0, 1, 13'h100, 32'h0,        3'd2));
        vecs.push_back(mk(0, 13'h000, 32'h0,        1, 13'h020, 1, 0, 32'hD0D00020, 0, 1, 13'h020, 32'h0,        3'd2));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h030, 32'h30,       3'd1));
        vecs.push_back(mk(1, 13'h032, 32'h32,       0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h031, 32'h31,       3'd1));
        vecs.push_back(mk(0, 13'h000, 32'h0,        0, 13'h000, 1, 0, 32'h0,        1, 0, 13'h032, 32'h32,       3'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lv, vecs[i].la);
            #1;
            check($sformatf("v%0d st_ready", i), 32'(sb.st_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d ld_hit", i), 32'(sb.ld_hit), 32'(vecs[i].hit));
            check($sformatf("v%0d ld_data", i), sb.ld_data, vecs[i].ldata);
            check($sformatf("v%0d memwrite", i), 32'(mem_memwrite), 32'(vecs[i].mw));
            check($sformatf("v%0d memread", i), 32'(mem_memread), 32'(vecs[i].mr));
            check($sformatf("v%0d mem_address", i), 32'(mem_address), 32'(vecs[i].maddr));
            check($sformatf("v%0d write_data", i), mem_write_data, vecs[i].wdata);
            @(posedge clk);
            #1 check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            @(negedge clk);
        end

        check("mem[005]", mem[13'h005], 32'h12345678);
        check("mem[001]", mem[13'h001], 32'h11);
        check("mem[004]", mem[13'h004], 32'h44);
        check("mem[010]", mem[13'h010], 32'hBBBB0000);
        check("mem[031]", mem[13'h031], 32'h31);
        check("mem[032]", mem[13'h032], 32'h32);

        // Reset with stores pending: they must be discarded, not written
        for (int i = 0; i < 3; i++) begin
            drive(1, 13'(13'h040 + i), 32'(32'h40 + i), 1, 13'h100);
            @(negedge clk);
        end
        #1 check("pre-reset count", 32'(count), 32'd3);
        drive(0, '0, '0, 0, '0);
        rst_n = 1'b0;
        #1 check("in-reset memwrite", 32'(mem_memwrite), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post-reset count", 32'(count), 32'd0);
        check("post-reset empty", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("post-reset memwrite%0d", i), 32'(mem_memwrite), 32'd0);
        end
        check("mem[040]", mem[13'h040], 32'h0);
        check("mem[041]", mem[13'h041], 32'h0);
        check("mem[042]", mem[13'h042], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM pipeline stage and data_memory.
- Stores are queued and retire later, one per cycle, when data_memory's single address port is free.
- Loads check the buffer first and forward the youngest matching store. On a miss they read data_memory directly through the same port.
- Drives data_memory's address, write_data, memread and memwrite inputs.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- ADDR_W, 13, word address width; matches data_memory.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_ready  out  1  buffer accepts the store (not full).
- st_addr  in  ADDR_W  store word address.
- st_data  in  DATA_W  store data.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  ADDR_W  load word address.
- ld_data  out  DATA_W  load result (combinational).
- ld_hit  out  1  load was served from the buffer.
- mem_address  out  ADDR_W  to data_memory address.
- mem_write_data  out  DATA_W  to data_memory write_data.
- mem_memread  out  1  to data_memory memread.
- mem_memwrite  out  1  to data_memory memwrite.
- empty  out  1  no pending stores; used by pipeline fence/halt.
- count  out  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset (rst_n=0 at posedge):
  - head=tail=count=0; all entries invalid; pending stores are discarded, never written.
  - While count=0 and ld_valid=0, outputs are: st_ready=1, empty=1, mem_memwrite=0, mem_memread=0, mem_address=0, mem_write_data=0, ld_data=0, ld_hit=0.
- Storage: circular FIFO of {addr, data} entries. Push at tail, pop at head, pointers wrap modulo DEPTH.
- Push:
  - Occurs when st_valid && st_ready at posedge. st_ready = (count != DEPTH), derived from registered count only.
  - A store presented while full is not accepted; upstream holds it and stalls.
- Load forwarding (combinational):
  - Compare ld_addr against all valid entries.
  - ld_hit = ld_valid && any match; ld_data = data of the youngest match, i.e. the match closest to tail.
  - On a miss, ld_data = data_memory read_data, which is passed through the memory port.
- Memory port arbitration (combinational; one user per cycle):
  - Load miss (ld_valid && !ld_hit): mem_address=ld_addr, mem_memread=1, mem_memwrite=0. Drain stalls this cycle.
  - Otherwise, if count>0: mem_address=head.addr, mem_write_data=head.data, mem_memwrite=1, mem_memread=0. The entry pops at the same posedge that data_memory writes it.
  - Otherwise the port is idle, with all-zero outputs.
- Drain latency: an entry pushed at edge N can be written at edge N+1 at the earliest, when the port is free.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any count < DEPTH.
- Full with drain in the same cycle: st_ready stays 0 that cycle; there is no combinational ready-from-pop path.
- Same-cycle store and load to the same address: the incoming store is not visible to the load. The pipeline guarantees the load is older.
- Duplicate addresses: no coalescing. Entries drain in program order, so memory ends with the youngest value.
- count is always ≤ DEPTH. A pop is never issued with count=0, and a push is never accepted with count=DEPTH.

Decomposition:
- Package sb_pkg holds:
  - constants ADDR_W=13, DATA_W=32, SB_DEPTH=4;
  - typedef sb_entry_t {addr, data};
  - typedef mem_req_t {address, write_data, memread, memwrite}.
- One sub-module, store_buffer_match: a youngest-first priority match across DEPTH entries, given head, count and ld_addr. It returns hit and data.

Test Plan:
- Reset, then idle: empty=1, count=0, st_ready=1, mem_memwrite=0 and mem_memread=0 for 5 cycles.
- Push store 0x005←0x12345678 with no load: count=1 after the edge. Next cycle mem_address=0x005 and mem_memwrite=1; after that edge count=0 and data_memory[5]=0x12345678.
- Push four stores (0x001..0x004) while holding a load miss to 0x100 throughout, so no drain occurs:
  - count=4 and st_ready=0;
  - a fifth store is not accepted, and count remains 4;
  - releasing the load drains all four in order 0x001..0x004 on consecutive cycles.
- Push 0x010←0xAAAA0000, then 0x010←0xBBBB0000, while a load miss to 0x100 blocks drain. Then load 0x010: ld_hit=1 and ld_data=0xBBBB0000. After the drain completes, data_memory[0x010]=0xBBBB0000.
- Load miss to 0x020 while count=2: mem_memread=1, mem_address=0x020, mem_memwrite=0. Buffer count is unchanged across that edge, and drain resumes the next cycle.
- Push three stores, then assert rst_n=0 for one edge: count=0 and empty=1. No mem_memwrite pulses follow, and the memory contents are unchanged.
